// File: rtl/legv8_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// legv8_ctrl_pkg
// Shared types and constants for the LEGv8 multi-cycle control unit:
//   - state_e       : controller FSM states
//   - instr_class_e : instruction class produced by the opcode decoder
//   - opcode field constants (11-bit R/D, 8-bit CB, 6-bit B)
//   - aluOP encodings
// -----------------------------------------------------------------------------
package legv8_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

  // ILLEGAL is encoded as zero so that a cleared class register is harmless.
  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_RTYPE   = 3'd1,
    CLS_LDUR    = 3'd2,
    CLS_STUR    = 3'd3,
    CLS_CBZ     = 3'd4,
    CLS_B       = 3'd5
  } instr_class_e;

  localparam int OPCODE_W = 11;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // D-type classes share the address-generation EXEC step and visit MEM.
  function automatic logic is_dtype(input instr_class_e cls);
    return (cls == CLS_LDUR) || (cls == CLS_STUR);
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// -----------------------------------------------------------------------------
// multicycle_controller_if
// Bundles the memory handshakes and datapath control strobes of the
// multi-cycle controller.
//   master : the controller (drives strobes/indices, samples memory status)
//   slave  : memory + datapath side (drives instruction/readies)
// Signals: instruction, instrReady, memReady (to controller);
//          instrReq, irWrite, pcWrite, branch, unconditionalBranch, memRead,
//          memWrite, memToReg, aluSRC, aluOP, regWriteFlag, readRegister1/2,
//          writeRegister, fault (from controller).
// -----------------------------------------------------------------------------
interface multicycle_controller_if #(
  parameter int INSTR_W    = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 2
);
  logic [INSTR_W-1:0]    instruction;
  logic                  instrReady;
  logic                  memReady;
  logic                  instrReq;
  logic                  irWrite;
  logic                  pcWrite;
  logic                  branch;
  logic                  unconditionalBranch;
  logic                  memRead;
  logic                  memWrite;
  logic                  memToReg;
  logic                  aluSRC;
  logic [ALUOP_W-1:0]    aluOP;
  logic                  regWriteFlag;
  logic [REG_ADDR_W-1:0] readRegister1;
  logic [REG_ADDR_W-1:0] readRegister2;
  logic [REG_ADDR_W-1:0] writeRegister;
  logic                  fault;

  modport master (
    input  instruction, instrReady, memReady,
    output instrReq, irWrite, pcWrite, branch, unconditionalBranch,
           memRead, memWrite, memToReg, aluSRC, aluOP, regWriteFlag,
           readRegister1, readRegister2, writeRegister, fault
  );

  modport slave (
    output instruction, instrReady, memReady,
    input  instrReq, irWrite, pcWrite, branch, unconditionalBranch,
           memRead, memWrite, memToReg, aluSRC, aluOP, regWriteFlag,
           readRegister1, readRegister2, writeRegister, fault
  );
endinterface

// File: rtl/legv8_opcode_decode.sv
// -----------------------------------------------------------------------------
// legv8_opcode_decode
// Purely combinational opcode classifier.
// Ports:
//   opcode      in  11  instruction bits [31:21]
//   instr_class out     RTYPE / LDUR / STUR / CBZ / B / ILLEGAL
//   reg2loc     out  1  second read port takes Rt (IR[4:0]) instead of Rm
// -----------------------------------------------------------------------------
module legv8_opcode_decode
  import legv8_ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output instr_class_e        instr_class,
  output logic                reg2loc
);

  always_comb begin
    instr_class = CLS_ILLEGAL;
    reg2loc     = 1'b0;
    if (opcode == OP_LDUR) begin
      instr_class = CLS_LDUR;
    end else if (opcode == OP_STUR) begin
      // Store data comes from Rt, so port 2 reads IR[4:0].
      instr_class = CLS_STUR;
      reg2loc     = 1'b1;
    end else if ((opcode == OP_ADD) || (opcode == OP_SUB) ||
                 (opcode == OP_AND) || (opcode == OP_ORR)) begin
      instr_class = CLS_RTYPE;
    end else if (opcode[10:3] == OP_CBZ) begin
      // CBZ tests Rt for zero through the ALU pass-B path.
      instr_class = CLS_CBZ;
      reg2loc     = 1'b1;
    end else if (opcode[10:5] == OP_B) begin
      instr_class = CLS_B;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// LEGv8 multi-cycle control unit. Latches a fetched instruction and walks it
// through FETCH -> DECODE -> EXEC -> [MEM] -> [WB], emitting control strobes.
// FETCH and MEM stall on their ready handshakes for at most WAIT_LIMIT cycles
// before entering a sticky FAULT state that only reset leaves.
// Ports:
//   clock  in   system clock, rising edge
//   reset  in   asynchronous, active-high
//   bus    master modport of multicycle_controller_if (memory handshakes,
//          control strobes, register indices, fault)
// -----------------------------------------------------------------------------
module multicycle_controller
  import legv8_ctrl_pkg::*;
#(
  parameter int INSTR_W    = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 2,
  parameter int WAIT_LIMIT = 15,
  parameter int WAIT_W     = 4   // 2**WAIT_W must exceed WAIT_LIMIT
)(
  input  logic clock,
  input  logic reset,
  multicycle_controller_if.master bus
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  instr_class_e       cls_q, cls_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;

  instr_class_e       dec_class;
  logic               dec_reg2loc;
  logic [WAIT_W-1:0]  wait_inc;
  logic               wait_expired;

  // Decode always looks at the latched IR, so readRegister2 is already steered
  // correctly during DECODE, before the class register is loaded.
  legv8_opcode_decode u_decode (
    .opcode      (ir_q[INSTR_W-1 -: OPCODE_W]),
    .instr_class (dec_class),
    .reg2loc     (dec_reg2loc)
  );

  // Immediate, shift amount and upper address bits are datapath concerns.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir_q[15:10];

  assign wait_inc     = wait_q + WAIT_W'(1);
  assign wait_expired = (wait_inc == WAIT_W'(WAIT_LIMIT));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cls_d   = cls_q;
    wait_d  = wait_q;

    unique case (state_q)
      ST_FETCH: begin
        // A ready on the expiring cycle still wins.
        if (bus.instrReady) begin
          ir_d    = bus.instruction;
          state_d = ST_DECODE;
        end else if (wait_expired) begin
          state_d = ST_FAULT;
        end else begin
          wait_d = wait_inc;
        end
      end
      ST_DECODE: begin
        cls_d   = dec_class;
        state_d = (dec_class == CLS_ILLEGAL) ? ST_FAULT : ST_EXEC;
      end
      ST_EXEC: begin
        unique case (cls_q)
          CLS_RTYPE:          state_d = ST_WB;
          CLS_LDUR, CLS_STUR: state_d = ST_MEM;
          CLS_CBZ, CLS_B:     state_d = ST_FETCH;
          default:            state_d = ST_FAULT;
        endcase
      end
      ST_MEM: begin
        if (bus.memReady) begin
          state_d = (cls_q == CLS_LDUR) ? ST_WB : ST_FETCH;
        end else if (wait_expired) begin
          state_d = ST_FAULT;
        end else begin
          wait_d = wait_inc;
        end
      end
      ST_WB:    state_d = ST_FETCH;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase

    // Each state gets a fresh stall budget.
    if (state_d != state_q) begin
      wait_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      cls_q   <= CLS_ILLEGAL;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cls_q   <= cls_d;
      wait_q  <= wait_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Moore outputs (irWrite is the one strobe that follows the fetch handshake)
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.instrReq            = 1'b0;
    bus.irWrite             = 1'b0;
    bus.pcWrite             = 1'b0;
    bus.branch              = 1'b0;
    bus.unconditionalBranch = 1'b0;
    bus.memRead             = 1'b0;
    bus.memWrite            = 1'b0;
    bus.memToReg            = 1'b0;
    bus.aluSRC              = 1'b0;
    bus.aluOP               = ALUOP_W'(ALUOP_ADD);
    bus.regWriteFlag        = 1'b0;
    bus.fault               = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        bus.instrReq = 1'b1;
        // Masked by reset so no load pulse escapes while reset is held.
        bus.irWrite  = bus.instrReady && !reset;
      end
      ST_EXEC: begin
        unique case (cls_q)
          CLS_RTYPE: begin
            bus.pcWrite = 1'b1;
            bus.aluOP   = ALUOP_W'(ALUOP_FUNCT);
          end
          CLS_LDUR, CLS_STUR: begin
            bus.pcWrite = 1'b1;
            bus.aluSRC  = 1'b1;
            bus.aluOP   = ALUOP_W'(ALUOP_ADD);
          end
          CLS_CBZ: begin
            // PC+4 vs target is chosen outside using branch & ALU zero.
            bus.branch = 1'b1;
            bus.aluOP  = ALUOP_W'(ALUOP_PASSB);
          end
          CLS_B: begin
            bus.unconditionalBranch = 1'b1;
            bus.pcWrite             = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        bus.memRead  = (cls_q == CLS_LDUR);
        bus.memWrite = (cls_q == CLS_STUR);
      end
      ST_WB: begin
        bus.regWriteFlag = 1'b1;
        bus.memToReg     = (cls_q == CLS_LDUR);
      end
      ST_FAULT: bus.fault = 1'b1;
      default: ;
    endcase
  end

  // Indices come straight from the IR; they are zero after reset.
  assign bus.readRegister1 = REG_ADDR_W'(ir_q[9:5]);
  assign bus.readRegister2 = dec_reg2loc ? REG_ADDR_W'(ir_q[4:0])
                                         : REG_ADDR_W'(ir_q[20:16]);
  assign bus.writeRegister = REG_ADDR_W'(ir_q[4:0]);

  // D-type helper kept visible for the EXEC/MEM pairing.
  logic unused_dtype;
  assign unused_dtype = is_dtype(cls_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
// Randomized scoreboard bench. A transaction-level model turns each
// instruction (plus its chosen fetch/memory stall counts) into the list of
// per-cycle control words it should produce; a monitor pops and compares one
// word per cycle on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

  localparam int WL = 15;

  // strobe vector bit positions
  localparam int S_IREQ = 12, S_IRW = 11, S_PCW = 10, S_BR = 9, S_UB = 8;
  localparam int S_MRD = 7, S_MWR = 6, S_M2R = 5, S_ASRC = 4, S_AOP = 2;
  localparam int S_RW = 1, S_FLT = 0;

  typedef enum int {K_R, K_LDUR, K_STUR, K_CBZ, K_B, K_ILL} kind_t;

  typedef struct {
    logic [12:0] strb;
    logic [4:0]  rr1, rr2, wr;
    bit          chk_rr, chk_wr;
    string       tag;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  multicycle_controller_if #(.INSTR_W(32), .REG_ADDR_W(5), .ALUOP_W(2)) bus();

  multicycle_controller #(
    .INSTR_W(32), .REG_ADDR_W(5), .ALUOP_W(2), .WAIT_LIMIT(WL), .WAIT_W(4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic logic [12:0] dut_strb();
    return {bus.instrReq, bus.irWrite, bus.pcWrite, bus.branch,
            bus.unconditionalBranch, bus.memRead, bus.memWrite, bus.memToReg,
            bus.aluSRC, bus.aluOP, bus.regWriteFlag, bus.fault};
  endfunction

  function automatic exp_t blank(input string tag);
    exp_t e;
    e.strb = '0; e.rr1 = '0; e.rr2 = '0; e.wr = '0;
    e.chk_rr = 0; e.chk_wr = 0; e.tag = tag;
    return e;
  endfunction

  // Instruction classification straight from the ISA opcode table.
  function automatic kind_t classify(input logic [31:0] w);
    if (w[31:21] == 11'h7C2) return K_LDUR;
    if (w[31:21] == 11'h7C0) return K_STUR;
    if (w[31:21] == 11'h458 || w[31:21] == 11'h658 ||
        w[31:21] == 11'h450 || w[31:21] == 11'h550) return K_R;
    if (w[31:24] == 8'hB4) return K_CBZ;
    if (w[31:26] == 6'h05) return K_B;
    return K_ILL;
  endfunction

  // Monitor: one expected control word per cycle.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [12:0] g;
      logic [14:0] gi, ei;
      e  = exp_q.pop_front();
      g  = dut_strb();
      gi = {e.chk_rr ? bus.readRegister1 : 5'd0, e.chk_rr ? bus.readRegister2 : 5'd0,
            e.chk_wr ? bus.writeRegister : 5'd0};
      ei = {e.chk_rr ? e.rr1 : 5'd0, e.chk_rr ? e.rr2 : 5'd0, e.chk_wr ? e.wr : 5'd0};
      vectors++;
      if (g !== e.strb || gi !== ei) begin
        miscompares++;
        $display("FAIL %s: got strb=%b idx=%h, want strb=%b idx=%h",
                 e.tag, g, gi, e.strb, ei);
      end
    end
  end

  // One clock cycle of stimulus with its expected control word.
  task automatic cyc(input logic ir_rdy, input logic mem_rdy,
                     input logic [31:0] w, input exp_t e);
    bus.instrReady  = ir_rdy;
    bus.memReady    = mem_rdy;
    bus.instruction = w;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic fault_cycles(input string tag);
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      e = blank({tag, "/fault"});
      e.strb[S_FLT] = 1'b1;
      cyc(1'($urandom), 1'($urandom), $urandom, e);
    end
  endtask

  // Asynchronous reset out of FAULT, checked before any clock edge.
  task automatic reset_from_fault(input string tag);
    logic [12:0] want;
    #2;
    reset = 1'b1;
    #1;
    want = '0;
    want[S_IREQ] = 1'b1;
    vectors++;
    if (dut_strb() !== want || bus.readRegister1 !== 5'd0 ||
        bus.writeRegister !== 5'd0 || bus.fault !== 1'b0) begin
      miscompares++;
      $display("FAIL %s/async_reset: got strb=%b rr1=%0d wr=%0d, want strb=%b rr1=0 wr=0",
               tag, dut_strb(), bus.readRegister1, bus.writeRegister, want);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Expected behaviour of one instruction, fs fetch stalls, ms memory stalls.
  task automatic run_instr(input logic [31:0] w, input int fs, input int ms,
                           input string tag);
    exp_t  e;
    kind_t k;
    logic [4:0] r1, r2;
    k  = classify(w);
    r1 = w[9:5];
    r2 = (k == K_STUR || k == K_CBZ) ? w[4:0] : w[20:16];

    for (int i = 0; i < fs && i < WL; i++) begin
      e = blank({tag, "/fetch_wait"});
      e.strb[S_IREQ] = 1'b1;
      cyc(1'b0, 1'($urandom), $urandom, e);
    end
    if (fs >= WL) begin
      fault_cycles(tag);
      reset_from_fault(tag);
      return;
    end

    e = blank({tag, "/fetch"});
    e.strb[S_IREQ] = 1'b1; e.strb[S_IRW] = 1'b1;
    cyc(1'b1, 1'($urandom), w, e);

    e = blank({tag, "/decode"});
    e.rr1 = r1; e.rr2 = r2; e.chk_rr = 1;
    cyc(1'($urandom), 1'($urandom), $urandom, e);
    if (k == K_ILL) begin
      fault_cycles(tag);
      reset_from_fault(tag);
      return;
    end

    e = blank({tag, "/exec"});
    e.rr1 = r1; e.rr2 = r2; e.chk_rr = 1;
    case (k)
      K_R:            begin e.strb[S_PCW] = 1; e.strb[S_AOP +: 2] = 2'b10; end
      K_LDUR, K_STUR: begin e.strb[S_PCW] = 1; e.strb[S_ASRC] = 1; end
      K_CBZ:          begin e.strb[S_BR] = 1; e.strb[S_AOP +: 2] = 2'b01; end
      default:        begin e.strb[S_UB] = 1; e.strb[S_PCW] = 1; end
    endcase
    cyc(1'($urandom), 1'($urandom), $urandom, e);

    if (k == K_LDUR || k == K_STUR) begin
      for (int i = 0; i <= ms && i < WL; i++) begin
        e = blank({tag, "/mem"});
        e.rr1 = r1; e.rr2 = r2; e.chk_rr = 1;
        if (k == K_LDUR) e.strb[S_MRD] = 1; else e.strb[S_MWR] = 1;
        cyc(1'($urandom), (i == ms) ? 1'b1 : 1'b0, $urandom, e);
      end
      if (ms >= WL) begin
        fault_cycles(tag);
        reset_from_fault(tag);
        return;
      end
    end

    if (k == K_R || k == K_LDUR) begin
      e = blank({tag, "/wb"});
      e.rr1 = r1; e.rr2 = r2; e.chk_rr = 1; e.wr = w[4:0]; e.chk_wr = 1;
      e.strb[S_RW] = 1;
      if (k == K_LDUR) e.strb[S_M2R] = 1;
      cyc(1'($urandom), 1'($urandom), $urandom, e);
    end
  endtask

  function automatic logic [31:0] rand_word(input kind_t k);
    logic [31:0] w;
    logic [10:0] rops [4];
    rops[0] = 11'h458; rops[1] = 11'h658; rops[2] = 11'h450; rops[3] = 11'h550;
    w = $urandom;
    case (k)
      K_R:    w[31:21] = rops[$urandom_range(0, 3)];
      K_LDUR: begin w[31:21] = 11'h7C2; w[11:10] = 2'b00; end
      K_STUR: begin w[31:21] = 11'h7C0; w[11:10] = 2'b00; end
      K_CBZ:  w[31:24] = 8'hB4;
      K_B:    w[31:26] = 6'h05;
      default: while (classify(w) != K_ILL) w = $urandom;
    endcase
    return w;
  endfunction

  task automatic check_reset_values(input string tag);
    logic [12:0] want;
    want = '0;
    want[S_IREQ] = 1'b1;
    vectors++;
    if (dut_strb() !== want || bus.readRegister1 !== 5'd0 ||
        bus.readRegister2 !== 5'd0 || bus.writeRegister !== 5'd0) begin
      miscompares++;
      $display("FAIL %s: got strb=%b rr=%0d/%0d wr=%0d, want strb=%b rr=0/0 wr=0",
               tag, dut_strb(), bus.readRegister1, bus.readRegister2,
               bus.writeRegister, want);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    kind_t k;
    int fs, ms;
    reset = 1'b1;
    bus.instrReady  = 1'b0;
    bus.memReady    = 1'b0;
    bus.instruction = '0;
    @(posedge clock);
    #1;
    check_reset_values("reset");
    bus.instrReady = 1'b1;
    #1;
    check_reset_values("reset_ready_high");
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Directed cases
    run_instr(32'h8B020023, 0, 0, "add");
    run_instr(32'hF8408025, 0, 3, "ldur_stall3");
    run_instr(32'hF8000047, 0, 0, "stur");
    run_instr(32'hB4000044, 0, 0, "cbz");
    run_instr(32'h14000010, 0, 0, "b");
    run_instr(32'h00000000, 0, 0, "illegal0");
    run_instr(32'hF8408025, 0, WL, "ldur_timeout");
    run_instr(32'hF8408025, 0, WL - 1, "ldur_ready_at_limit");
    run_instr(32'hF8000047, 0, WL, "stur_timeout");
    run_instr(32'hF8000047, 0, WL - 1, "stur_ready_at_limit");
    run_instr(32'h8B020023, WL, 0, "fetch_timeout");
    run_instr(32'h8B020023, WL - 1, 0, "fetch_ready_at_limit");

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      k  = kind_t'($urandom_range(0, 12) > 10 ? 5 : $urandom_range(0, 4));
      fs = ($urandom_range(0, 19) == 0) ? $urandom_range(WL - 1, WL) : $urandom_range(0, 3);
      ms = ($urandom_range(0, 19) == 0) ? $urandom_range(WL - 1, WL) : $urandom_range(0, 3);
      run_instr(rand_word(k), fs, ms, "rand");
    end

    // Bounded drain of anything still queued.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clock);
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multi-cycle control unit for the LEGv8 datapath and successor to the single-cycle decoder. Latches a fetched 32-bit instruction and steps it through FETCH/DECODE/EXEC/MEM/WB. Emits per-state control strobes and register indices, and stalls on instruction-memory and data-memory ready handshakes with a bounded wait. Sits between the instruction/data memory interfaces and the register file, ALU and PC logic.

Parameters:
INSTR_W, 32, instruction word width; the opcode field is always bits [INSTR_W-1:INSTR_W-11]
REG_ADDR_W, 5, register index width
ALUOP_W, 2, aluOP width; 00=add, 01=pass-B/zero-test, 10=funct-decode
WAIT_LIMIT, 15, maximum stall cycles in FETCH or MEM before FAULT
WAIT_W, 4, counter width; must satisfy 2^WAIT_W > WAIT_LIMIT

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
instruction  in  INSTR_W  fetched instruction word, valid when instrReady=1
instrReady  in  1  instruction memory has data this cycle
memReady  in  1  data memory has completed the access this cycle
instrReq  out  1  instruction fetch request
irWrite  out  1  one-cycle pulse: instruction register loaded
pcWrite  out  1  unconditional PC update (PC+4 or branch target)
branch  out  1  conditional branch; PC logic gates it with ALU zero
unconditionalBranch  out  1  B-type target select
memRead  out  1  data memory read
memWrite  out  1  data memory write
memToReg  out  1  write-back source is memory
aluSRC  out  1  ALU B operand is sign-extended immediate
aluOP  out  ALUOP_W  ALU operation class
regWriteFlag  out  1  register file write enable
readRegister1  out  REG_ADDR_W  Rn = IR[9:5]
readRegister2  out  REG_ADDR_W  Rt = IR[4:0] if reg2Loc, else Rm = IR[20:16]
writeRegister  out  REG_ADDR_W  Rd/Rt = IR[4:0]
fault  out  1  sticky: illegal opcode or memory timeout

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, FAULT. Reset enters FETCH asynchronously, clears IR, class and wait counter, and deasserts fault.
- Outputs are Moore: decoded from the state register and the latched IR/class only. Reset values are all 0 except instrReq=1 (FETCH). Register indices are 0 because IR=0.
- FETCH:
  - instrReq=1.
  - On instrReady: IR<=instruction, irWrite=1 that cycle, go to DECODE.
  - Otherwise increment the wait counter; on reaching WAIT_LIMIT, go to FAULT.
  - Wait counter clears on every state change.
- DECODE: classify IR[31:21]; class is held in a register until the next DECODE.
  - LDUR 11111000010 and STUR 11111000000: D-type.
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000: R-type.
  - CBZ when IR[31:24]=10110100; B when IR[31:26]=000101.
  - Anything else goes to FAULT.
  - reg2Loc=1 for STUR and CBZ. readRegister1/2 become valid from DECODE onward.
- EXEC:
  - R-type: aluOP=10, aluSRC=0, then WB.
  - D-type: aluOP=00, aluSRC=1, then MEM.
  - CBZ: aluOP=01, branch=1, then FETCH.
  - B: unconditionalBranch=1, pcWrite=1, then FETCH.
  - In EXEC for R/D-type, pcWrite=1 (PC+4). CBZ with zero=0 relies on external PC+4 selection under branch.
- MEM:
  - LDUR holds memRead=1; STUR holds memWrite=1. Both stay asserted until memReady.
  - On memReady: LDUR goes to WB, STUR goes to FETCH.
  - Timeout rule is the same as FETCH.
- WB: regWriteFlag=1 for exactly one cycle, writeRegister=IR[4:0], memToReg=1 for LDUR only, then FETCH.
- FAULT: all strobes 0, fault=1. Only reset exits.
- Zero-wait latencies, counted as cycles from entering FETCH to re-entering FETCH: R-type 4, LDUR 5, STUR 4, CBZ/B 3.
- instrReady outside FETCH and memReady outside MEM are ignored.
- A ready arriving on the same cycle the counter reaches WAIT_LIMIT wins: the handshake completes and there is no fault.

Decomposition:
- Package legv8_ctrl_pkg holds:
  - the state enum;
  - the instruction-class enum (RTYPE, LDUR, STUR, CBZ, B, ILLEGAL);
  - opcode constants;
  - aluOP encodings.
- One natural sub-module, legv8_opcode_decode: a combinational opcode-to-class and reg2Loc function, reusable by a future pipelined controller.

Test Plan:
- ADD X3,X1,X2 (0x8B020023), instrReady and memReady tied 1 -> irWrite at cycle 0; readRegister1=1, readRegister2=2 from DECODE; aluOP=10 in EXEC; regWriteFlag=1, writeRegister=3 in WB; back in FETCH at cycle 4.
- LDUR X5,[X1,#8] (0xF8408025), memReady low 3 cycles in MEM -> memRead held 4 cycles; then WB with memToReg=1, regWriteFlag=1, writeRegister=5; total 8 cycles.
- STUR X7,[X2,#0] (0xF8000047) -> readRegister2=7 (reg2Loc); memWrite 1 cycle; regWriteFlag never asserted; 4 cycles.
- CBZ X4 (0xB4000044) and B (0x14000010) -> branch=1 with aluOP=01 and readRegister2=4, 3 cycles; B gives unconditionalBranch=1 and pcWrite=1, 3 cycles.
- Opcode 0x000 (word 0x00000000) -> DECODE goes to FAULT, fault=1, all strobes 0; async reset mid-FAULT -> FETCH, instrReq=1, fault=0 immediately without a clock edge.
- memReady held 0 in MEM for WAIT_LIMIT (15) cycles -> FAULT; repeat with memReady arriving on cycle 15 -> no fault, normal completion.
